ar_split_ctrl: RTL

- Read-address controller for the AXI data-width adapter: accepts one wide-side (master) AR burst and splits it into one or more narrow-side (slave) INCR sub-bursts.
- Pushes the per-transaction descriptor {sub_xfer_cnt, total_sub_txn} into the transfer FIFO. The R-channel datapath uses this descriptor to pack narrow beats and count slave RLASTs.
- Sits between the master AR port and the slave AR port, upstream of the transfer FIFO.

---
 rtl/ar_split_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ar_split_ctrl.sv
// Splits one wide-side AR burst into narrow-side INCR sub-bursts and pushes the packing descriptor.
// Optional outstanding-transaction limit: define AR_OUTSTANDING_LIMIT_EN.
module ar_split_ctrl #(
    parameter int unsigned M_DATA_WIDTH    = 128,
    parameter int unsigned S_DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned ARID_WIDTH      = 3,
    parameter int unsigned M_LEN_WIDTH     = 4,
    parameter int unsigned S_MAX_BEATS     = 16,
    parameter int unsigned SUB_TXN_CNT     = 3,
    parameter int unsigned SUB_XFER_CNT    = 3,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                              aclk,
    input  logic                              arst,
    input  logic [ARID_WIDTH-1:0]             m_arid,
    input  logic [ADDR_WIDTH-1:0]             m_araddr,
    input  logic [M_LEN_WIDTH-1:0]            m_arlen,
    input  logic [2:0]                        m_arsize,
    input  logic                              m_arvalid,
    output logic                              m_arready,
    output logic [ARID_WIDTH-1:0]             s_arid,
    output logic [ADDR_WIDTH-1:0]             s_araddr,
    output logic [7:0]                        s_arlen,
    output logic [2:0]                        s_arsize,
    output logic [1:0]                        s_arburst,
    output logic                              s_arvalid,
    input  logic                              s_arready,
    input  logic                              xfer_full,
    output logic                              xfer_wr_valid_o,
    output logic [SUB_TXN_CNT+SUB_XFER_CNT-1:0] xfer_data_i,
    input  logic                              m_rvalid,
    input  logic                              m_rready,
    input  logic                              m_rlast
);

    localparam int unsigned SB      = $clog2(S_DATA_WIDTH / 8);
    localparam int unsigned MB      = $clog2(M_DATA_WIDTH / 8);
    localparam int unsigned DESC_W  = SUB_TXN_CNT + SUB_XFER_CNT;
    localparam logic [2:0]  SB_L    = 3'(SB);
    localparam logic [2:0]  MB_L    = 3'(MB);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]            state_q, state_d;
    logic                  m_arready_q, m_arready_d;
    logic [ARID_WIDTH-1:0] s_arid_q, s_arid_d;
    logic [ADDR_WIDTH-1:0] s_araddr_q, s_araddr_d;
    logic [7:0]            s_arlen_q, s_arlen_d;
    logic [2:0]            s_arsize_q, s_arsize_d;
    logic                  s_arvalid_q, s_arvalid_d;
    logic [6:0]            rem_q, rem_d;
    logic                  xfer_wr_q, xfer_wr_d;
    logic [DESC_W-1:0]     xfer_data_q, xfer_data_d;

    logic                  m_hs_c;
    logic                  limit_next_c;
    logic [2:0]            eff_size_c, size_c;
    logic [3:0]            sub_cnt_c;
    logic [6:0]            tb_c, total_c, beats_c, rem_left_c;
    logic [ADDR_WIDTH-1:0] step_c;

    // Slave sub-burst length (minus 1) for a given number of remaining beats
    function automatic logic [7:0] sub_len(input logic [6:0] rem);
        if (rem > 7'(S_MAX_BEATS)) begin
            return 8'(S_MAX_BEATS - 1);
        end
        return 8'(rem) - 8'd1;
    endfunction

    assign m_hs_c = m_arvalid && m_arready_q;

    // Beat-size conversion and burst bookkeeping for the incoming master request
    always_comb begin
        eff_size_c = (m_arsize > MB_L) ? MB_L : m_arsize;
        size_c     = (eff_size_c > SB_L) ? SB_L : eff_size_c;
        sub_cnt_c  = 4'd1 << (eff_size_c - size_c);
        tb_c       = (7'(m_arlen) + 7'd1) * 7'(sub_cnt_c);
        total_c    = (tb_c + 7'(S_MAX_BEATS - 1)) / 7'(S_MAX_BEATS);
        beats_c    = 7'(s_arlen_q) + 7'd1;
        rem_left_c = rem_q - beats_c;
        step_c     = (ADDR_WIDTH'(s_arlen_q) + ADDR_WIDTH'(1)) << s_arsize_q;
    end

`ifdef AR_OUTSTANDING_LIMIT_EN
    logic [2:0] cnt_q, cnt_d;
    logic       r_done_c;

    assign r_done_c = m_rvalid && m_rready && m_rlast;

    always_comb begin
        cnt_d = cnt_q;
        if (m_hs_c && !r_done_c) begin
            cnt_d = cnt_q + 3'd1;
        end else if (!m_hs_c && r_done_c) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign limit_next_c = (cnt_d == 3'(MAX_OUTSTANDING));
`else
    logic unused_c;
    assign unused_c     = ^{m_rvalid, m_rready, m_rlast, 32'(MAX_OUTSTANDING)};
    assign limit_next_c = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        m_arready_d = 1'b0;
        s_arid_d    = s_arid_q;
        s_araddr_d  = s_araddr_q;
        s_arlen_d   = s_arlen_q;
        s_arsize_d  = s_arsize_q;
        s_arvalid_d = s_arvalid_q;
        rem_d       = rem_q;
        xfer_wr_d   = 1'b0;
        xfer_data_d = xfer_data_q;
        case (state_q)
            ST_IDLE: begin
                if (m_hs_c) begin
                    state_d     = ST_ISSUE;
                    s_arid_d    = m_arid;
                    s_araddr_d  = m_araddr;
                    s_arsize_d  = size_c;
                    s_arlen_d   = sub_len(tb_c);
                    s_arvalid_d = 1'b1;
                    rem_d       = tb_c;
                    xfer_wr_d   = 1'b1;
                    xfer_data_d = {SUB_XFER_CNT'(sub_cnt_c), SUB_TXN_CNT'(total_c)};
                end else begin
                    m_arready_d = !xfer_full && !limit_next_c;
                end
            end
            ST_ISSUE: begin
                if (s_arready) begin
                    s_araddr_d = s_araddr_q + step_c;
                    rem_d      = rem_left_c;
                    if (rem_left_c == 7'd0) begin
                        state_d     = ST_IDLE;
                        s_arvalid_d = 1'b0;
                        m_arready_d = !xfer_full && !limit_next_c;
                    end else begin
                        s_arlen_d = sub_len(rem_left_c);
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                s_arvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q     <= ST_IDLE;
            m_arready_q <= 1'b0;
            s_arid_q    <= '0;
            s_araddr_q  <= '0;
            s_arlen_q   <= 8'd0;
            s_arsize_q  <= 3'd0;
            s_arvalid_q <= 1'b0;
            rem_q       <= 7'd0;
            xfer_wr_q   <= 1'b0;
            xfer_data_q <= '0;
        end else begin
            state_q     <= state_d;
            m_arready_q <= m_arready_d;
            s_arid_q    <= s_arid_d;
            s_araddr_q  <= s_araddr_d;
            s_arlen_q   <= s_arlen_d;
            s_arsize_q  <= s_arsize_d;
            s_arvalid_q <= s_arvalid_d;
            rem_q       <= rem_d;
            xfer_wr_q   <= xfer_wr_d;
            xfer_data_q <= xfer_data_d;
        end
    end

    assign m_arready       = m_arready_q;
    assign s_arid          = s_arid_q;
    assign s_araddr        = s_araddr_q;
    assign s_arlen         = s_arlen_q;
    assign s_arsize        = s_arsize_q;
    assign s_arburst       = 2'b01;
    assign s_arvalid       = s_arvalid_q;
    assign xfer_wr_valid_o = xfer_wr_q;
    assign xfer_data_i     = xfer_data_q;

endmodule
